shift_rows_pipe: RTL



---
 rtl/shift_rows_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/shift_rows_pipe.sv
// Registered, handshaked Rijndael ShiftRows/InvShiftRows stage for NB = 4, 6 or 8 columns.
// Define SHIFTROWS_SKID_EN for a 2-entry skid buffer with registered in_ready.
`timescale 1ns/1ps
module shift_rows_pipe #(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned W      = 32 * NB;
  localparam int unsigned NBYTES = 4 * NB;

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  // Rijndael row offsets; the 256-bit block widens rows 2 and 3 by one.
  function automatic int unsigned row_shift(input int unsigned r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  logic [W-1:0] shifted_c;
  logic         in_fire;
  logic         out_fire;

  // Pure byte routing: each output byte selects one input byte of the same row.
  always_comb begin
    int unsigned src;
    src       = 0;
    shifted_c = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < NB; c++) begin
        src = in_inv ? (c + NB - row_shift(r)) % NB : (c + row_shift(r)) % NB;
        shifted_c[8*(NBYTES-1-(r+4*c)) +: 8] = in_data[8*(NBYTES-1-(r+4*src)) +: 8];
      end
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef SHIFTROWS_SKID_EN

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       out_data_d;
  logic [TAG_W-1:0]   out_tag_d;
  logic [W-1:0]       skid_data_q, skid_data_d;
  logic [TAG_W-1:0]   skid_tag_q, skid_tag_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      out_data    <= '0;
      out_tag     <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid   <= (state_d != EMPTY);
      in_ready    <= (state_d != TWO);
      out_data    <= out_data_d;
      out_tag     <= out_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

  // Occupancy FSM: output register first, skid entry only when output is stalled.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data;
    out_tag_d   = out_tag;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d    = ONE;
          out_data_d = shifted_c;
          out_tag_d  = in_tag;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          out_data_d = shifted_c;
          out_tag_d  = in_tag;
        end else if (in_fire) begin
          state_d     = TWO;
          skid_data_d = shifted_c;
          skid_tag_d  = in_tag;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d    = ONE;
          out_data_d = skid_data_q;
          out_tag_d  = skid_tag_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

`else

  assign in_ready = !out_valid || out_ready;

  // Single output register; a new block may replace the one leaving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= shifted_c;
      out_tag   <= in_tag;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule
